mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DW, 32, data width of all data buses.
REQ-002 Parameter: AW, 32, address width of all address buses.
REQ-003 Parameter: WAIT, 1, extra RAM wait cycles per access (0..15).
REQ-004 Port: clk  in  1  clock; all state updates on rising edge.
REQ-005 Port: rst  in  1  reset, synchronous, active-high.
REQ-006 Port: i_req  in  1  instruction-fetch read request; held until i_ack.
REQ-007 Port: i_addr  in  AW  fetch address.
REQ-008 Port: i_rdata  out  DW  fetched word, valid while i_ack=1, held afterwards.
REQ-009 Port: i_ack  out  1  one-cycle completion pulse for fetch port.
REQ-010 Port: d_req  in  1  data-port request (MEM-stage chip enable); held until d_ack.
REQ-011 Port: d_we  in  1  1=store, 0=load.
REQ-012 Port: d_addr  in  AW  data address.
REQ-013 Port: d_wdata  in  DW  store data.
REQ-014 Port: d_rdata  out  DW  load result, valid while d_ack=1, held afterwards.
REQ-015 Port: d_ack  out  1  one-cycle completion pulse for data port.
REQ-016 Port: stall_o  out  1  pipeline stall = (i_req & ~i_ack) | (d_req & ~d_ack), combinational.
REQ-017 Port: ram_ce, ram_we  out  1 each  single-port RAM enable / write enable.
REQ-018 Port: ram_addr, ram_wdata  out  AW, DW  RAM address / write data.
REQ-019 Port: ram_rdata  in  DW  RAM read data, valid WAIT+1 cycles after ram_ce first asserted.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, RESP; one access in flight at a time.
REQ-021 IDLE: no request -> stay; d_req only -> grant D; i_req only -> grant I; both -> grant D unless fair flag set, then grant I.
REQ-022 Fair flag SHALL set when D is granted while i_req=1, and clear on any I grant; guarantees alternation under contention.
REQ-023 On grant (IDLE edge) owner, address, we (forced 0 for I) and wdata SHALL be registered; requester changes during ACCESS/RESP are ignored.
REQ-024 ACCESS SHALL last exactly WAIT+1 cycles, counted by a down-counter loaded with WAIT at grant; ram_ce=1, ram_we=registered we, ram_addr/ram_wdata from registers throughout.
REQ-025 On the edge ending the last ACCESS cycle, ram_rdata SHALL be captured into the owner's rdata register (reads only; writes leave d_rdata unchanged); FSM -> RESP.
REQ-026 RESP SHALL last one cycle: owner's ack=1, ram_ce=0, ram_we=0; then -> IDLE; no grant is made in RESP.
REQ-027 Latency: request seen in IDLE at cycle 0 -> ack in cycle WAIT+2; throughput one access per WAIT+3 cycles.
REQ-028 Outside ACCESS ram_ce=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-029 A request withdrawn mid-access SHALL NOT abort it; access completes and ack still pulses.
REQ-030 A requester still asserting req in the cycle after its ack SHALL be treated as a new request.

Reset
REQ-031 rst=1 at any edge SHALL force IDLE, counter=0, fair flag=0, i_ack=d_ack=0, i_rdata=d_rdata=0, ram_* outputs=0, aborting any access in flight without ack.

Verification (WAIT=1)
REQ-032 i_req=1, i_addr=0x100, ram_rdata=0x24020005 -> ram_ce=1 cycles 1-2, i_ack=1 cycle 3, i_rdata=0x24020005, stall_o=1 cycles 0-2.
REQ-033 d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> ram_we=1 cycles 1-2 with ram_addr=0x40, ram_wdata=0xDEADBEEF; d_ack cycle 3; d_rdata unchanged.
REQ-034 i_req and d_req both held continuously -> grant order D, I, D, I; acks at cycles 3, 7, 11, 15.
REQ-035 d_req load at 0x80, d_addr changed to 0x84 during ACCESS -> ram_addr stays 0x80 throughout; d_rdata = RAM word at 0x80.
REQ-036 rst=1 in cycle 2 of an I access -> next cycle IDLE, ram_ce=0, no i_ack, i_rdata=0; held i_req re-granted after rst drops.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port RAM with a fixed
// wait-state count; one access in flight, data-first with fairness under contention.
module mem_arbiter #(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 32,
  parameter int unsigned WAIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          stall_o,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            fair_q, fair_d;
  logic            own_data_q, own_data_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            i_ack_q, i_ack_d;
  logic            d_ack_q, d_ack_d;
  logic            ram_ce_q, ram_ce_d;
  logic            ram_we_q, ram_we_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DW-1:0]   ram_wdata_q, ram_wdata_d;

  logic            grant_d_c, grant_i_c, last_c;

  // Data port wins unless the fetch port was passed over last time.
  assign grant_d_c = (state_q == S_IDLE) && d_req && (!i_req || !fair_q);
  assign grant_i_c = (state_q == S_IDLE) && i_req && !grant_d_c;
  assign last_c    = (state_q == S_ACCESS) && (cnt_q == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (grant_d_c || grant_i_c) state_d = S_ACCESS;
      S_ACCESS: if (cnt_q == '0) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request capture at grant, wait-state counter and fairness flag.
  always_comb begin
    cnt_d      = cnt_q;
    fair_d     = fair_q;
    own_data_d = own_data_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if (grant_d_c) begin
      own_data_d = 1'b1;
      addr_d     = d_addr;
      we_d       = d_we;
      wdata_d    = d_wdata;
      cnt_d      = CW'(WAIT);
      fair_d     = fair_q | i_req;
    end else if (grant_i_c) begin
      own_data_d = 1'b0;
      addr_d     = i_addr;
      we_d       = 1'b0;
      wdata_d    = '0;
      cnt_d      = CW'(WAIT);
      fair_d     = 1'b0;
    end else if ((state_q == S_ACCESS) && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    i_ack_d     = last_c && !own_data_q;
    d_ack_d     = last_c && own_data_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    if (last_c && !we_q) begin
      if (own_data_q) d_rdata_d = ram_rdata;
      else            i_rdata_d = ram_rdata;
    end
    ram_ce_d    = (state_d == S_ACCESS);
    ram_we_d    = ram_ce_d && we_d;
    ram_addr_d  = ram_ce_d ? addr_d  : '0;
    ram_wdata_d = ram_ce_d ? wdata_d : '0;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      fair_q      <= 1'b0;
      own_data_q  <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      ram_ce_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      fair_q      <= fair_d;
      own_data_q  <= own_data_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
      ram_ce_q    <= ram_ce_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign ram_ce    = ram_ce_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  // Pipeline stall is combinational on the live requests.
  assign stall_o = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, each cycle
// compared against a transaction-timestamp reference model and a RAM model.
module tb_mem_arbiter;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 32;
  localparam int unsigned WAIT = 1;

  logic          clk;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          stall_o;
  logic          ram_ce;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  mem_arbiter #(.DW(DW), .AW(AW), .WAIT(WAIT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .stall_o(stall_o),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: data only valid from the (WAIT+1)-th consecutive enabled cycle.
  logic [DW-1:0] ram_mem [256];
  int unsigned   ce_cnt = 0;
  always @(posedge clk) begin
    ce_cnt <= ram_ce ? ce_cnt + 1 : 0;
    if (ram_ce && ram_we) ram_mem[ram_addr[9:2]] <= ram_wdata;
  end
  assign ram_rdata = (ram_ce && ce_cnt >= WAIT) ? ram_mem[ram_addr[9:2]] : 32'hBAD0_0BAD;

  int checks   = 0;
  int failures = 0;

  // Reference model: one transaction at a time, timed from its grant cycle.
  logic [DW-1:0] ref_mem [256];
  int unsigned   cyc = 0;
  bit            busy = 0;
  int unsigned   t0 = 0;
  bit            m_own_d = 0;
  bit            m_fair = 0;
  logic [AW-1:0] m_addr = '0;
  bit            m_we = 0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_i_rdata = '0;
  logic [DW-1:0] m_d_rdata = '0;
  int unsigned   iack_q[$];
  int unsigned   dack_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return {22'h0, 8'($urandom_range(0, 255)), 2'b00};
  endfunction

  // One clock cycle: compare outputs with the model, advance the model, move to next cycle.
  task automatic step();
    int unsigned k;
    bit e_acc, e_resp, e_iack, e_dack;
    #1;
    k      = busy ? cyc - t0 : 0;
    e_acc  = busy && k >= 1 && k <= WAIT + 1;
    e_resp = busy && k == WAIT + 2;
    e_iack = e_resp && !m_own_d;
    e_dack = e_resp && m_own_d;
    chk("ram_ce",    ram_ce,    e_acc);
    chk("ram_we",    ram_we,    e_acc && m_we);
    chk("ram_addr",  ram_addr,  e_acc ? m_addr : '0);
    chk("ram_wdata", ram_wdata, e_acc ? m_wdata : '0);
    chk("i_ack",     i_ack,     e_iack);
    chk("d_ack",     d_ack,     e_dack);
    chk("i_rdata",   i_rdata,   m_i_rdata);
    chk("d_rdata",   d_rdata,   m_d_rdata);
    chk("stall_o",   stall_o,   (i_req && !e_iack) || (d_req && !e_dack));
    if (i_ack === 1'b1) iack_q.push_back(cyc);
    if (d_ack === 1'b1) dack_q.push_back(cyc);
    if (e_acc && m_we) ref_mem[m_addr[9:2]] = m_wdata;
    if (rst) begin
      busy = 0; m_fair = 0; m_i_rdata = '0; m_d_rdata = '0;
    end else if (busy) begin
      if (k == WAIT + 1 && !m_we) begin
        if (m_own_d) m_d_rdata = ref_mem[m_addr[9:2]];
        else         m_i_rdata = ref_mem[m_addr[9:2]];
      end
      if (k == WAIT + 2) busy = 0;
    end else if (d_req && (!i_req || !m_fair)) begin
      busy = 1; t0 = cyc; m_own_d = 1;
      m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
      if (i_req) m_fair = 1;
    end else if (i_req) begin
      busy = 1; t0 = cyc; m_own_d = 0;
      m_addr = i_addr; m_we = 0; m_wdata = '0;
      m_fair = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  function automatic int unsigned rel(input int unsigned q[$], input int idx, input int unsigned base);
    return (idx < q.size()) ? q[idx] - base : 32'hFFFF_FFFF;
  endfunction

  initial begin
    int unsigned base;
    bit got;
    logic [DW-1:0] word80;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 32'(i) * 32'h9E37_79B1;
      ref_mem[i] = 32'(i) * 32'h9E37_79B1;
    end
    ram_mem[8'h40] = 32'h2402_0005;
    ref_mem[8'h40] = 32'h2402_0005;
    word80 = ref_mem[8'h20];
    rst = 1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    step();                             // reset state
    rst = 0;
    step();

    // Single fetch with latency check.
    iack_q.delete(); base = cyc;
    i_req = 1; i_addr = 32'h100;
    for (int n = 0; n < 4; n++) step();
    i_req = 0;
    chk("fetch_ack_cycle", rel(iack_q, 0, base), 3);
    chk("fetch_rdata", i_rdata, 32'h2402_0005);
    step();

    // Single store; load result register must not change.
    dack_q.delete(); base = cyc;
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    for (int n = 0; n < 4; n++) step();
    d_req = 0; d_we = 0;
    chk("store_ack_cycle", rel(dack_q, 0, base), 3);
    chk("store_d_rdata", d_rdata, '0);
    chk("store_ram_word", ram_mem[8'h10], 32'hDEAD_BEEF);
    step();

    // Contention: both ports held, alternating grants.
    iack_q.delete(); dack_q.delete(); base = cyc;
    i_req = 1; i_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h300;
    for (int n = 0; n < 16; n++) step();
    i_req = 0; d_req = 0;
    chk("cont_d_ack0", rel(dack_q, 0, base), 3);
    chk("cont_i_ack0", rel(iack_q, 0, base), 7);
    chk("cont_d_ack1", rel(dack_q, 1, base), 11);
    chk("cont_i_ack1", rel(iack_q, 1, base), 15);
    step();

    // Address changed during access is ignored.
    d_req = 1; d_we = 0; d_addr = 32'h80;
    step();
    d_addr = 32'h84;
    chk("load_addr_c1", ram_addr, 32'h80);
    step();
    chk("load_addr_c2", ram_addr, 32'h80);
    step();
    step();
    d_req = 0;
    chk("load_rdata", d_rdata, word80);
    step();

    // Request withdrawn after grant still completes.
    iack_q.delete(); base = cyc;
    i_req = 1; i_addr = 32'h104;
    step();
    i_req = 0;
    for (int n = 0; n < 4; n++) step();
    chk("withdraw_ack_cycle", rel(iack_q, 0, base), 3);

    // Reset in the middle of a fetch, then re-grant of the held request.
    rst = 1; step(); rst = 0; step();
    iack_q.delete(); base = cyc;
    i_req = 1; i_addr = 32'h100;
    step(); step();
    rst = 1; step();
    rst = 0;
    chk("rst_ram_ce", ram_ce, 1'b0);
    chk("rst_i_ack", i_ack, 1'b0);
    chk("rst_i_rdata", i_rdata, '0);
    got = 0;
    for (int n = 0; n < 12 && !got; n++) begin
      if (i_ack === 1'b1) got = 1;
      else step();
    end
    chk("rst_regrant", got, 1'b1);
    chk("rst_ack_count", iack_q.size(), 0);
    step();
    i_req = 0;
    step();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if (!i_req) begin
        if ($urandom_range(0, 2) == 0) begin i_req = 1; i_addr = rand_addr(); end
      end else if (i_ack) begin
        if ($urandom_range(0, 9) < 7) i_req = 0; else i_addr = rand_addr();
      end else begin
        if ($urandom_range(0, 39) == 0) i_req = 0;
        if ($urandom_range(0, 9) == 0) i_addr = rand_addr();
      end
      if (!d_req) begin
        if ($urandom_range(0, 2) == 0) begin
          d_req = 1; d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
        end
      end else if (d_ack) begin
        if ($urandom_range(0, 9) < 7) d_req = 0;
        else begin d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom; end
      end else begin
        if ($urandom_range(0, 39) == 0) d_req = 0;
        if ($urandom_range(0, 9) == 0) begin d_addr = rand_addr(); d_wdata = $urandom; end
      end
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0; i_req = 0; d_req = 0;
    for (int n = 0; n < 6; n++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
